// File: rtl/div_issue_ctrl_pkg.sv
// Shared types for the EX-stage divide issue/retire controller.
// alu_op_t is the core-wide ALU op encoding; div_state_t and DIV_CYCLES belong to the divide path.
package div_issue_ctrl_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, RESP} div_state_t;

  localparam int unsigned DIV_CYCLES = 32;

  function automatic logic is_div_op(alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_div(alu_op_t op);
    return op inside {ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request/response and divider-side bus of the divide controller.
// slave is the controller's view; master is the core/divider side.
interface div_issue_ctrl_if import div_issue_ctrl_pkg::*; #(
  parameter int unsigned XLEN = 32
) ();

  logic            req_valid_i;
  alu_op_t         req_op_i;
  logic [XLEN-1:0] req_rs1_i;
  logic [XLEN-1:0] req_rs2_i;
  logic [4:0]      req_rd_i;
  logic            req_ready_o;
  logic            stall_o;
  logic            flush_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] resp_data_o;
  logic [4:0]      resp_rd_o;
  alu_op_t         div_op_o;
  logic [XLEN-1:0] div_lhs_o;
  logic [XLEN-1:0] div_rhs_o;
  logic [XLEN-1:0] div_quo_u_i;
  logic [XLEN-1:0] div_rem_u_i;
  logic [XLEN-1:0] div_quo_s_i;
  logic [XLEN-1:0] div_rem_s_i;

  modport slave (
    input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
           div_quo_u_i, div_rem_u_i, div_quo_s_i, div_rem_s_i,
    output req_ready_o, stall_o, resp_valid_o, resp_data_o, resp_rd_o,
           div_op_o, div_lhs_o, div_rhs_o
  );

  modport master (
    output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
           div_quo_u_i, div_rem_u_i, div_quo_s_i, div_rem_s_i,
    input  req_ready_o, stall_o, resp_valid_o, resp_data_o, resp_rd_o,
           div_op_o, div_lhs_o, div_rhs_o
  );

endinterface

// File: rtl/div_issue_ctrl_special_case.sv
// Divide-by-zero and signed-overflow results resolved without the divider.
module div_special_case import div_issue_ctrl_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            special,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic zero;
  logic ovf;
  logic is_rem;

  always_comb begin
    zero    = (rs2 == '0);
    ovf     = is_signed_div(op) && (rs1 == SMIN) && (rs2 == '1);
    is_rem  = op inside {ALU_REM, ALU_REMU};
    special = is_div_op(op) && (zero || ovf);
    result  = '0;
    if (zero)
      result = is_rem ? rs1 : '1;
    else if (ovf)
      result = is_rem ? '0 : SMIN;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage issue/retire FSM for DIV/DIVU/REM/REMU: stalls, pulses the divider,
// counts its fixed latency and returns the selected result to writeback.
module div_issue_ctrl import div_issue_ctrl_pkg::*; #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DIV_CYCLES = div_issue_ctrl_pkg::DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  div_issue_ctrl_if.slave  bus
);

  localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES - 1);

  div_state_t      state_q;
  logic [5:0]      cnt_q;
  alu_op_t         op_q;
  logic [XLEN-1:0] lhs_q;
  logic [XLEN-1:0] rhs_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] data_q;

  logic            accept;
  logic            spec_hit;
  logic [XLEN-1:0] spec_result;
  logic [XLEN-1:0] sel_result;

  div_special_case #(.XLEN(XLEN)) u_special (
    .op      (bus.req_op_i),
    .rs1     (bus.req_rs1_i),
    .rs2     (bus.req_rs2_i),
    .special (spec_hit),
    .result  (spec_result)
  );

  assign accept = (state_q == IDLE) && bus.req_valid_i && is_div_op(bus.req_op_i) && !bus.flush_i;

  always_comb begin
    case (op_q)
      ALU_DIVU: sel_result = bus.div_quo_u_i;
      ALU_REMU: sel_result = bus.div_rem_u_i;
      ALU_DIV:  sel_result = bus.div_quo_s_i;
      ALU_REM:  sel_result = bus.div_rem_s_i;
      default:  sel_result = '0;
    endcase
  end

  // Flush cannot abort the divider, so the count always runs to completion
  // before IDLE; a flush landing on the final WAIT cycle goes straight to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_ADD;
      lhs_q   <= '0;
      rhs_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.req_op_i;
            lhs_q <= bus.req_rs1_i;
            rhs_q <= bus.req_rs2_i;
            rd_q  <= bus.req_rd_i;
            if (spec_hit) begin
              data_q  <= spec_result;
              state_q <= RESP;
            end else begin
              state_q <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= bus.flush_i ? DRAIN : WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            data_q  <= sel_result;
            state_q <= bus.flush_i ? IDLE : RESP;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (bus.flush_i)
              state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.stall_o      = accept || (state_q == LAUNCH) || (state_q == WAIT);
  assign bus.resp_valid_o = (state_q == RESP);
  assign bus.resp_data_o  = data_q;
  assign bus.resp_rd_o    = rd_q;
  // Any divide encoding here restarts the divider, so it is only driven in LAUNCH.
  assign bus.div_op_o     = (state_q == LAUNCH) ? op_q : ALU_ADD;
  assign bus.div_lhs_o    = lhs_q;
  assign bus.div_rhs_o    = rhs_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural 32-cycle divider model.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_issue_ctrl_if #(.XLEN(32)) bus ();

  div_issue_ctrl #(.XLEN(32), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int at; logic [31:0] data; logic [4:0] rd; } resp_t;
  typedef struct { int at; alu_op_t op; logic [31:0] a; logic [31:0] b; } launch_t;
  typedef struct { alu_op_t op; logic [31:0] a; logic [31:0] b; logic [31:0] e; } vec_t;

  resp_t   resp_q[$];
  launch_t launch_q[$];
  resp_t   mr;
  launch_t ml;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  function automatic bit ref_special(alu_op_t op, logic [31:0] a, logic [31:0] b);
    return (b == 32'd0) || ((op == ALU_DIV || op == ALU_REM) && a == SMIN && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic ovf;
    ovf = (a == SMIN) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 32'd0) ? a : a % b;
      ALU_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? SMIN : 32'($signed(a) / $signed(b));
      ALU_REM:  return (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default:  return 32'd0;
    endcase
  endfunction

  // Divider model: loads when a divide op is seen, result valid only in the 32nd cycle after.
  logic        div_busy = 1'b0;
  int          div_k = 0;
  logic [31:0] ma = '0;
  logic [31:0] mb = '0;
  logic        good;
  logic [31:0] qu, ru, qs, rs;

  always @(posedge clk) begin
    if (rst) begin
      div_busy <= 1'b0;
      div_k    <= 0;
    end else if (is_div_op(bus.div_op_o)) begin
      div_busy <= 1'b1;
      div_k    <= 1;
      ma       <= bus.div_lhs_o;
      mb       <= bus.div_rhs_o;
    end else if (div_busy) begin
      if (div_k == 32) div_busy <= 1'b0;
      else             div_k <= div_k + 1;
    end
  end

  always_comb begin
    good = div_busy && (div_k == 32);
    qu   = (mb == 32'd0) ? 32'd0 : ma / mb;
    ru   = (mb == 32'd0) ? 32'd0 : ma % mb;
    qs   = (mb == 32'd0) ? 32'd0 : 32'($signed(ma) / $signed(mb));
    rs   = (mb == 32'd0) ? 32'd0 : 32'($signed(ma) % $signed(mb));
    bus.div_quo_u_i = good ? qu : ~qu;
    bus.div_rem_u_i = good ? ru : ~ru;
    bus.div_quo_s_i = good ? qs : ~qs;
    bus.div_rem_s_i = good ? rs : ~rs;
  end

  // Monitor: pops expectations whenever the DUT presents a response or divider pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid_o) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got data %h rd %0d expected none (cycle %0d)",
                   bus.resp_data_o, bus.resp_rd_o, cyc);
        end else begin
          mr = resp_q.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(mr.at));
          chk("resp_data", bus.resp_data_o, mr.data);
          chk("resp_rd", 32'(bus.resp_rd_o), 32'(mr.rd));
        end
      end
      if (is_div_op(bus.div_op_o)) begin
        if (launch_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_launch: got op %0d expected none (cycle %0d)", bus.div_op_o, cyc);
        end else begin
          ml = launch_q.pop_front();
          chk("launch_cycle", 32'(cyc), 32'(ml.at));
          chk("launch_op", 32'(bus.div_op_o), 32'(ml.op));
          chk("launch_lhs", bus.div_lhs_o, ml.a);
          chk("launch_rhs", bus.div_rhs_o, ml.b);
        end
      end
      if (div_busy) begin
        chk("lhs_hold", bus.div_lhs_o, ma);
        chk("rhs_hold", bus.div_rhs_o, mb);
      end
    end
  end

  // Caller is always positioned at a negedge.
  task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_data, input bit want_resp,
                       output int acc);
    int w;
    bit sp;
    w = 0;
    while (!bus.req_ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got ready 0 expected 1 (cycle %0d)", cyc);
    end
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_rs1_i   = a;
    bus.req_rs2_i   = b;
    bus.req_rd_i    = rd;
    bus.flush_i     = 1'b0;
    #1;
    chk("stall_on_accept", 32'(bus.stall_o), 32'd1);
    acc = cyc;
    sp  = ref_special(op, a, b);
    if (want_resp) resp_q.push_back('{at: acc + (sp ? 1 : 34), data: exp_data, rd: rd});
    if (!sp) launch_q.push_back('{at: acc + 1, op: op, a: a, b: b});
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = ALU_ADD;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((resp_q.size() != 0 || launch_q.size() != 0 || !bus.req_ready_o) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got %0d pending expected 0 (cycle %0d)", resp_q.size(), cyc);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_resp_data", bus.resp_data_o, 32'd0);
    chk("rst_resp_rd", 32'(bus.resp_rd_o), 32'd0);
    chk("rst_div_op", 32'(bus.div_op_o), 32'(ALU_ADD));
    chk("rst_div_lhs", bus.div_lhs_o, 32'd0);
    chk("rst_div_rhs", bus.div_rhs_o, 32'd0);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
  endtask

  vec_t dir [9] = '{
    '{ALU_DIVU, 32'd100,        32'd7,          32'd14},
    '{ALU_REMU, 32'd100,        32'd7,          32'd2},
    '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
    '{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
    '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD},
    '{ALU_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF},
    '{ALU_REM,  32'd5,          32'd0,          32'd5},
    '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
    '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0}
  };

  alu_op_t rops [4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

  initial begin
    int acc;
    int acc2;
    alu_op_t op;
    logic [31:0] a, b;
    logic [4:0] rd;

    bus.req_valid_i = 1'b0;
    bus.req_op_i    = ALU_ADD;
    bus.req_rs1_i   = '0;
    bus.req_rs2_i   = '0;
    bus.req_rd_i    = '0;
    bus.flush_i     = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    foreach (dir[i]) begin
      issue(dir[i].op, dir[i].a, dir[i].b, 5'(i + 1), dir[i].e, 1'b1, acc);
      wait_idle();
    end

    // Non-divide ops and flushed divide requests are not accepted.
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = ALU_SUB;
    #1;
    chk("nondiv_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    chk("nondiv_ready", 32'(bus.req_ready_o), 32'd1);
    bus.req_op_i = ALU_DIVU;
    bus.flush_i  = 1'b1;
    #1;
    chk("flush_idle_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    chk("flush_idle_ready", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    @(negedge clk);

    // Flush in WAIT at cnt=10.
    issue(ALU_DIVU, 32'd50, 32'd5, 5'd3, 32'd0, 1'b0, acc);
    while (cyc < acc + 12) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("drain_stall", 32'(bus.stall_o), 32'd0);
    chk("drain_ready", 32'(bus.req_ready_o), 32'd0);
    while (cyc < acc + 33) @(negedge clk);
    chk("drain_ready_last", 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    chk("drain_ready_end", 32'(bus.req_ready_o), 32'd1);
    issue(ALU_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 1'b1, acc2);
    chk("accept_after_drain", 32'(acc2), 32'(acc + 34));
    wait_idle();

    // Flush during LAUNCH.
    issue(ALU_REM, 32'd77, 32'd6, 5'd5, 32'd0, 1'b0, acc);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("launch_flush_stall", 32'(bus.stall_o), 32'd0);
    issue(ALU_REMU, 32'd17, 32'd5, 5'd6, 32'd2, 1'b1, acc2);
    chk("accept_after_launch_flush", 32'(acc2), 32'(acc + 34));
    wait_idle();

    // Reset in WAIT at cnt=20.
    issue(ALU_DIVU, 32'd77, 32'd7, 5'd7, 32'd0, 1'b0, acc);
    while (cyc < acc + 22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    issue(ALU_DIVU, 32'd1000, 32'd10, 5'd8, 32'd100, 1'b1, acc);
    wait_idle();

    // Randomized ops, partly back-to-back.
    repeat (30) begin
      op = rops[$urandom_range(0, 3)];
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = SMIN; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50)); end
        3: begin a = ~32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 20)); end
        4: begin a = 32'($urandom_range(0, 1000)); b = ~32'($urandom_range(0, 20)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      issue(op, a, b, rd, ref_result(op, a, b), 1'b1, acc);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    chk("launch_queue_empty", 32'(launch_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
